// File: rtl/des_round_key_gen.sv
// des_round_key_gen
//   DES key-schedule stage that sits after PC-1. It captures the C0/D0 halves
//   and hands out the 16 round subkeys (PC-2 of the rotated halves), one per
//   valid/ready handshake: K1..K16 for encrypt, K16..K1 for decrypt.
//
//   Bit numbering: bus bit i carries FIPS bit i+1 (c_in/d_in bit 0 = FIPS
//   bit 1, subkey bit 0 = PC-2 output bit 1).
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request a new schedule (only looked at while idle)
//   decrypt        direction, sampled with start (0 = K1..K16, 1 = K16..K1)
//   c_in, d_in     28-bit C0 / D0 halves from PC-1
//   subkey         current round key (zero whenever subkey_valid is low)
//   subkey_valid   subkey/round_num valid
//   subkey_ready   consumer accepts the key when valid & ready
//   round_num      round index 1..16 of the presented key, 0 when idle
//   busy           high while the schedule is being generated
//   done           one-cycle pulse after the 16th key is accepted
module des_round_key_gen #(
    parameter logic [15:0] SHIFT1_MASK = 16'h8103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [4:0]  round_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, GEN} state_t;

    // PC-2 selection table, FIPS numbering (1..56), output bit 1 first.
    localparam logic [5:0] PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic        dir;
    logic [27:0] c_q, d_q;
    logic [4:0]  cnt;
    logic [55:0] cd;
    logic [47:0] pc2_out;
    logic        handshake, last;

    // FIPS left rotate (towards bit 1) is a right shift of the bus.
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    assign handshake = subkey_valid & subkey_ready;
    assign last      = dir ? (cnt == 5'd1) : (cnt == 5'd16);
    assign round_num = cnt;

    // Subkey is decoded from the registered halves only, never from inputs.
    assign cd = {d_q, c_q};
    for (genvar n = 0; n < 48; n++) begin : g_pc2
        assign pc2_out[n] = cd[PC2[n] - 6'd1];
    end
    assign subkey = subkey_valid ? pc2_out : 48'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dir          <= 1'b0;
            c_q          <= '0;
            d_q          <= '0;
            cnt          <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= GEN;
                        dir          <= decrypt;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                        if (decrypt) begin
                            // Total encrypt rotation is 28, so C16/D16 = C0/D0.
                            c_q <= c_in;
                            d_q <= d_in;
                            cnt <= 5'd16;
                        end else begin
                            c_q <= rotl(c_in, SHIFT1_MASK[0]);
                            d_q <= rotl(d_in, SHIFT1_MASK[0]);
                            cnt <= 5'd1;
                        end
                    end
                end
                GEN: begin
                    if (handshake) begin
                        if (last) begin
                            state        <= IDLE;
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            c_q          <= '0;
                            d_q          <= '0;
                            cnt          <= '0;
                        end else if (dir) begin
                            // Undo the shift of round cnt; for cnt=16 the
                            // 4-bit index wraps to 15, i.e. sh(16).
                            c_q <= rotr(c_q, SHIFT1_MASK[cnt[3:0] - 4'd1]);
                            d_q <= rotr(d_q, SHIFT1_MASK[cnt[3:0] - 4'd1]);
                            cnt <= cnt - 5'd1;
                        end else begin
                            // Shift for round cnt+1 lives at mask bit cnt.
                            c_q <= rotl(c_q, SHIFT1_MASK[cnt[3:0]]);
                            d_q <= rotl(d_q, SHIFT1_MASK[cnt[3:0]]);
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_key_gen.sv
module tb_des_round_key_gen;
    logic        clk = 0, rst_n = 0, start = 0, decrypt = 0, subkey_ready = 0;
    logic [27:0] c_in = '0, d_in = '0;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [4:0]  round_num;

    des_round_key_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
        .c_in(c_in), .d_in(d_in), .subkey(subkey), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .round_num(round_num), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    // FIPS shift schedule and PC-2 table (FIPS numbering)
    int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    logic [47:0] got_key[$];
    int          got_rn[$];
    int          stall_err, early_done, nstall;
    bit          done_ok, first_ok, timed_out;
    logic [27:0] C0, D0;

    function automatic logic [27:0] rev28(input logic [27:0] x);
        logic [27:0] r;
        for (int i = 0; i < 28; i++) r[i] = x[27-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = x[47-i];
        return r;
    endfunction

    // Reference: round r key from the cumulative left shift of C0/D0.
    function automatic logic [47:0] model_key(input logic [27:0] c0, input logic [27:0] d0, input int r);
        int s = 0;
        logic [55:0] cd;
        logic [47:0] k;
        for (int j = 0; j < r; j++) s += SH[j];
        for (int j = 0; j < 28; j++) begin
            cd[j]      = c0[(j + s) % 28];
            cd[28 + j] = d0[(j + s) % 28];
        end
        for (int n = 0; n < 48; n++) k[n] = cd[PC2[n] - 1];
        return k;
    endfunction

    // Drives one schedule and records accepted keys.
    // mode 0: ready=1, 1: 5-cycle stall at round 3 then toggle,
    // 2: random ready, 3: ready=1 plus a start pulse at round 7.
    task automatic run_seq(input logic [27:0] c0, input logic [27:0] d0, input logic dec, input int mode);
        bit stalled_prev = 0, bp = 0, tog = 1, pulsed = 0;
        int hold = 0;
        logic r;
        logic [47:0] pk = '0;
        logic [4:0] prn = '0;
        got_key.delete(); got_rn.delete();
        stall_err = 0; early_done = 0; nstall = 0; done_ok = 0; timed_out = 0;
        @(negedge clk);
        start = 1; decrypt = dec; c_in = c0; d_in = d0;
        @(negedge clk);
        start = 0; decrypt = ~dec; c_in = $urandom; d_in = $urandom;
        first_ok = subkey_valid;
        for (int cyc = 0; cyc < 300 && got_key.size() < 16; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 0;
            if (done) early_done++;
            if (stalled_prev && (!subkey_valid || subkey !== pk || round_num !== prn)) stall_err++;
            r = 1;
            case (mode)
                1: begin
                    if (!bp && round_num == 5'd3) begin bp = 1; hold = 5; end
                    if (hold > 0) begin r = 0; hold--; end
                    else if (bp) begin r = tog; tog = ~tog; end
                end
                2: r = 1'($urandom_range(0, 1));
                3: if (!pulsed && round_num == 5'd7) begin
                       pulsed = 1; start = 1; decrypt = ~dec; c_in = $urandom; d_in = $urandom;
                   end
                default: r = 1;
            endcase
            subkey_ready = r;
            if (subkey_valid && r) begin got_key.push_back(subkey); got_rn.push_back(int'(round_num)); end
            if (subkey_valid && !r) nstall++;
            stalled_prev = subkey_valid && !r;
            pk = subkey; prn = round_num;
        end
        if (got_key.size() < 16) timed_out = 1;
        else begin
            @(negedge clk);
            start = 0;
            done_ok = done;
        end
        subkey_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        nchk++; if (subkey_valid !== 1'b0) begin nerr++; $display("FAIL reset valid got %b exp 0", subkey_valid); end
        nchk++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset busy got %b exp 0", busy); end
        nchk++; if (round_num !== 5'd0)    begin nerr++; $display("FAIL reset round_num got %0d exp 0", round_num); end
        nchk++; if (subkey !== 48'd0)      begin nerr++; $display("FAIL reset subkey got %h exp 0", subkey); end
        nchk++; if (done !== 1'b0)         begin nerr++; $display("FAIL reset done got %b exp 0", done); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_encrypt;
        run_seq(C0, D0, 0, 0);
        nchk++;
        if (timed_out) begin nerr++; $display("FAIL enc timeout got %0d keys exp 16", got_key.size()); return; end
        nchk++; if (!first_ok) begin nerr++; $display("FAIL enc first_latency valid got 0 exp 1"); end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (got_key[i] !== model_key(C0, D0, i + 1) || got_rn[i] != i + 1) begin
                nerr++; $display("FAIL enc key[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_rn[i], model_key(C0, D0, i + 1), i + 1);
            end
        end
        nchk++; if (got_key[0] !== rev48(48'h1B02EFFC7072))  begin nerr++; $display("FAIL enc K1_vector got %h exp %h", got_key[0], rev48(48'h1B02EFFC7072)); end
        nchk++; if (got_key[15] !== rev48(48'hCB3D8B0E17F5)) begin nerr++; $display("FAIL enc K16_vector got %h exp %h", got_key[15], rev48(48'hCB3D8B0E17F5)); end
        nchk++; if (!done_ok || early_done != 0) begin nerr++; $display("FAIL enc done got %b early %0d exp 1/0", done_ok, early_done); end
        @(negedge clk);
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0 || round_num !== 5'd0 || subkey !== 48'd0) begin
            nerr++; $display("FAIL enc idle_after got busy %b done %b rn %0d key %h exp 0", busy, done, round_num, subkey);
        end
    endtask

    task automatic test_decrypt;
        run_seq(C0, D0, 1, 0);
        nchk++;
        if (timed_out) begin nerr++; $display("FAIL dec timeout got %0d keys exp 16", got_key.size()); return; end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (got_key[i] !== model_key(C0, D0, 16 - i) || got_rn[i] != 16 - i) begin
                nerr++; $display("FAIL dec key[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_rn[i], model_key(C0, D0, 16 - i), 16 - i);
            end
        end
        nchk++; if (got_key[0] !== rev48(48'hCB3D8B0E17F5)) begin nerr++; $display("FAIL dec first_vector got %h", got_key[0]); end
        nchk++; if (!done_ok) begin nerr++; $display("FAIL dec done got 0 exp 1"); end
    endtask

    task automatic test_backpressure;
        run_seq(C0, D0, 0, 1);
        nchk++;
        if (timed_out) begin nerr++; $display("FAIL bp timeout got %0d keys exp 16", got_key.size()); return; end
        nchk++; if (stall_err != 0) begin nerr++; $display("FAIL bp stable got %0d violations exp 0", stall_err); end
        nchk++; if (nstall < 5) begin nerr++; $display("FAIL bp stall_cycles got %0d exp >=5", nstall); end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (got_key[i] !== model_key(C0, D0, i + 1) || got_rn[i] != i + 1) begin
                nerr++; $display("FAIL bp key[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_rn[i], model_key(C0, D0, i + 1), i + 1);
            end
        end
        nchk++; if (!done_ok || early_done != 0) begin nerr++; $display("FAIL bp done got %b early %0d", done_ok, early_done); end
    endtask

    task automatic test_start_in_gen;
        logic [27:0] cx, dx;
        bit seen;
        run_seq(C0, D0, 0, 3);
        nchk++;
        if (timed_out) begin nerr++; $display("FAIL sgen timeout got %0d keys exp 16", got_key.size()); return; end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (got_key[i] !== model_key(C0, D0, i + 1) || got_rn[i] != i + 1) begin
                nerr++; $display("FAIL sgen key[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_rn[i], model_key(C0, D0, i + 1), i + 1);
            end
        end
        nchk++; if (!done_ok) begin nerr++; $display("FAIL sgen done got 0 exp 1"); end
        // still in the done cycle: a start here must be accepted
        cx = $urandom; dx = $urandom;
        start = 1; decrypt = 0; c_in = cx; d_in = dx;
        @(negedge clk);
        start = 0;
        nchk++;
        if (subkey_valid !== 1'b1 || round_num !== 5'd1 || subkey !== model_key(cx, dx, 1)) begin
            nerr++; $display("FAIL done_start got v%b rn %0d key %h exp v1 rn 1 key %h", subkey_valid, round_num, subkey, model_key(cx, dx, 1));
        end
        subkey_ready = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        subkey_ready = 0;
        nchk++; if (!seen) begin nerr++; $display("FAIL done_start drain got no done exp done"); end
    endtask

    task automatic test_reset_midrun;
        bit hit = 0, dn = 0;
        @(negedge clk);
        start = 1; decrypt = 0; c_in = C0; d_in = D0;
        @(negedge clk);
        start = 0; subkey_ready = 1;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (round_num == 5'd9) hit = 1; else @(negedge clk);
        end
        nchk++; if (!hit) begin nerr++; $display("FAIL rst_mid reach_round9 got 0 exp 1"); end
        #2 rst_n = 0;
        #1;
        nchk++;
        if (subkey_valid !== 1'b0 || busy !== 1'b0 || round_num !== 5'd0 || subkey !== 48'd0) begin
            nerr++; $display("FAIL rst_mid async got v%b b%b rn %0d key %h exp 0", subkey_valid, busy, round_num, subkey);
        end
        repeat (3) begin @(negedge clk); if (done) dn = 1; end
        rst_n = 1; subkey_ready = 0;
        @(negedge clk); if (done) dn = 1;
        nchk++; if (dn) begin nerr++; $display("FAIL rst_mid done got 1 exp 0"); end
        run_seq(C0, D0, 0, 0);
        nchk++;
        if (timed_out) begin nerr++; $display("FAIL rst_mid timeout got %0d keys", got_key.size()); return; end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (got_key[i] !== model_key(C0, D0, i + 1) || got_rn[i] != i + 1) begin
                nerr++; $display("FAIL rst_mid key[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_rn[i], model_key(C0, D0, i + 1), i + 1);
            end
        end
    endtask

    task automatic test_weak;
        logic [27:0] pat;
        logic [47:0] ek;
        for (int w = 0; w < 2; w++) begin
            pat = (w == 0) ? 28'h0 : 28'hFFFFFFF;
            ek  = (w == 0) ? 48'h0 : 48'hFFFFFFFFFFFF;
            run_seq(pat, pat, 0, 0);
            nchk++;
            if (timed_out) begin nerr++; $display("FAIL weak%0d timeout", w); continue; end
            for (int i = 0; i < 16; i++) begin
                nchk++;
                if (got_key[i] !== ek) begin nerr++; $display("FAIL weak%0d key[%0d] got %h exp %h", w, i, got_key[i], ek); end
            end
        end
    endtask

    task automatic test_random;
        logic [27:0] c0, d0;
        logic dec;
        int r;
        for (int t = 0; t < 6; t++) begin
            c0 = $urandom; d0 = $urandom; dec = 1'($urandom_range(0, 1));
            run_seq(c0, d0, dec, 2);
            nchk++;
            if (timed_out) begin nerr++; $display("FAIL rand%0d timeout", t); continue; end
            nchk++; if (stall_err != 0 || !done_ok) begin nerr++; $display("FAIL rand%0d stall/done got %0d/%b exp 0/1", t, stall_err, done_ok); end
            for (int i = 0; i < 16; i++) begin
                r = dec ? 16 - i : i + 1;
                nchk++;
                if (got_key[i] !== model_key(c0, d0, r) || got_rn[i] != r) begin
                    nerr++; $display("FAIL rand%0d key[%0d] got %h/%0d exp %h/%0d", t, i, got_key[i], got_rn[i], model_key(c0, d0, r), r);
                end
            end
        end
    endtask

    initial begin
        C0 = rev28(28'hF0CCAAF);
        D0 = rev28(28'h556678F);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_start_in_gen();
        test_reset_midrun();
        test_weak();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
